// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared 4-bit ALU (add/mul/or/and), registered in and out.
// Define ALU_RR_ARBITER_STATS_EN to add the per-requester grant counters gcnt0/gcnt1.
module alu_rr_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [W-1:0]      a0,
  input  logic [W-1:0]      b0,
  input  logic [1:0]        op0,
  input  logic [W-1:0]      a1,
  input  logic [W-1:0]      b1,
  input  logic [1:0]        op1,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    result,
`ifdef ALU_RR_ARBITER_STATS_EN
  output logic [7:0]        gcnt0,
  output logic [7:0]        gcnt1,
`endif
  output logic              busy
);

  // state | meaning
  // IDLE  | no owner; sample req, pick winner, capture its operands
  // EXEC  | ALU evaluates captured operands; result and done registered
  // RESP  | done pulse visible; release grant and record last owner
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q;
  logic [1:0]    op_q;
  logic          win_q;
  logic          last_grant;
  logic          win_nxt;
  logic [2*W-1:0] alu_out;
  logic [2*W-1:0] a_ext, b_ext;

  // On contention the requester that did not own the ALU last time wins.
  always_comb begin
    win_nxt = req[1];
    if (req == 2'b11) win_nxt = ~last_grant;
  end

  assign a_ext = {{W{1'b0}}, a_q};
  assign b_ext = {{W{1'b0}}, b_q};

  always_comb begin
    alu_out = '0;
    case (op_q)
      2'b00: alu_out = a_ext + b_ext;
      2'b01: alu_out = a_ext * b_ext;
      2'b10: alu_out = a_ext | b_ext;
      2'b11: alu_out = a_ext & b_ext;
      default: alu_out = '0;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      win_q      <= 1'b0;
      last_grant <= 1'b1;
      grant      <= '0;
      done       <= '0;
      result     <= '0;
`ifdef ALU_RR_ARBITER_STATS_EN
      gcnt0      <= '0;
      gcnt1      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          grant <= '0;
          if (req != '0) begin
            win_q <= win_nxt;
            grant <= NREQ'(1) << win_nxt;
            a_q   <= win_nxt ? a1  : a0;
            b_q   <= win_nxt ? b1  : b0;
            op_q  <= win_nxt ? op1 : op0;
            state <= EXEC;
`ifdef ALU_RR_ARBITER_STATS_EN
            if (win_nxt) gcnt1 <= gcnt1 + 8'd1;
            else         gcnt0 <= gcnt0 + 8'd1;
`endif
          end
        end
        EXEC: begin
          result <= alu_out;
          done   <= NREQ'(1) << win_q;
          state  <= RESP;
        end
        RESP: begin
          last_grant <= win_q;
          grant      <= '0;
          done       <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: driver queues expected (owner, result); negedge monitor checks each done.
module tb_alu_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic [1:0] grant, done;
  logic [7:0] result;
  logic       busy;
`ifdef ALU_RR_ARBITER_STATS_EN
  logic [7:0] gcnt0, gcnt1;
`endif

  alu_rr_arbiter #(.W(4), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .op0(op0),
    .a1(a1), .b1(b1), .op1(op1),
    .grant(grant), .done(done), .result(result),
`ifdef ALU_RR_ARBITER_STATS_EN
    .gcnt0(gcnt0), .gcnt1(gcnt1),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] who; logic [7:0] res; } exp_t;
  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [1:0] prev_done = '0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req_v);
    end
  endtask

  // Monitor: every done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && done != 2'b00) begin
      if (prev_done != 2'b00) begin
        n_vec++; n_bad++;
        $display("FAIL done_width: done=%b held for more than one cycle", done);
      end
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: done=%b result=0x%02h with empty scoreboard", done, result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_done", {6'b0, done}, {6'b0, e.who});
        check("sb_grant", {6'b0, grant}, {6'b0, e.who});
        check("sb_result", result, e.res);
      end
    end
    prev_done = rst ? 2'b00 : done;
  end

  task automatic push(input logic [1:0] who, input logic [7:0] res);
    exp_t e;
    e.who = who; e.res = res;
    exp_q.push_back(e);
  endtask

  // Waits for n done pulses, drops req in the last done cycle.
  task automatic wait_done(input int n, input int budget);
    int got = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done != 2'b00) got++;
      if (got == n) begin
        req = 2'b00;
        @(negedge clk);
        return;
      end
    end
    req = 2'b00;
    n_vec++; n_bad++;
    $display("FAIL timeout: %0d of %0d done pulses seen", got, n);
  endtask

  initial begin
    rst = 1'b1; req = '0;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    repeat (2) @(negedge clk);
    check("rst_grant",  {6'b0, grant}, 8'h00);
    check("rst_done",   {6'b0, done},  8'h00);
    check("rst_result", result,        8'h00);
    check("rst_busy",   {7'b0, busy},  8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Single multiply from requester 0 with cycle-exact checks.
    a0 = 4'd3; b0 = 4'd5; op0 = 2'b01; req = 2'b01;
    push(2'b01, 8'h0F);
    @(negedge clk);
    check("t1_grant_exec", {6'b0, grant}, 8'h01);
    check("t1_busy_exec",  {7'b0, busy},  8'h01);
    check("t1_done_exec",  {6'b0, done},  8'h00);
    @(negedge clk);
    check("t1_done_resp",  {6'b0, done},  8'h01);
    check("t1_grant_resp", {6'b0, grant}, 8'h01);
    req = 2'b00;
    @(negedge clk);
    check("t1_grant_idle", {6'b0, grant}, 8'h00);
    check("t1_busy_idle",  {7'b0, busy},  8'h00);
    check("t1_result_hold", result,       8'h0F);

    // Requester 1 alone: OR then AND, upper nibble must stay zero.
    a1 = 4'hA; b1 = 4'h6; op1 = 2'b10; req = 2'b10;
    push(2'b10, 8'h0E);
    wait_done(1, 20);
    op1 = 2'b11; req = 2'b10;
    push(2'b10, 8'h02);
    wait_done(1, 20);

    // Continuous contention: last owner was 1, so 0,1,0,1.
    a0 = 4'd15; b0 = 4'd15; op0 = 2'b01;
    a1 = 4'd9;  b1 = 4'd7;  op1 = 2'b00;
    push(2'b01, 8'hE1); push(2'b10, 8'h10);
    push(2'b01, 8'hE1); push(2'b10, 8'h10);
    req = 2'b11;
    wait_done(4, 40);

    // Operand changed after grant must not affect the result.
    a0 = 4'd2; b0 = 4'd3; op0 = 2'b00; req = 2'b01;
    push(2'b01, 8'h05);
    @(negedge clk);
    a0 = 4'd7; b0 = 4'd7;
    wait_done(1, 20);

    // Reset in EXEC: no done, everything cleared, requester 0 wins next.
    a0 = 4'd1; b0 = 4'd1; op0 = 2'b00; req = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_grant",  {6'b0, grant}, 8'h00);
    check("rst_mid_done",   {6'b0, done},  8'h00);
    check("rst_mid_result", result,        8'h00);
    check("rst_mid_busy",   {7'b0, busy},  8'h00);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a0 = 4'd4; b0 = 4'd6; op0 = 2'b11;
    a1 = 4'd1; b1 = 4'd1; op1 = 2'b00;
    push(2'b01, 8'h04); push(2'b10, 8'h02);
    req = 2'b11;
    wait_done(2, 20);

`ifdef ALU_RR_ARBITER_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("gcnt0_rst", gcnt0, 8'd0);
    a0 = 4'd1; b0 = 4'd1; op0 = 2'b00;
    for (int i = 0; i < 300; i++) push(2'b01, 8'h02);
    req = 2'b01;
    wait_done(300, 1200);
    check("gcnt0_wrap", gcnt0, 8'd44);
    check("gcnt1_hold", gcnt1, 8'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
